// File: rtl/udps_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udps_test_pkg
// Purpose  : Shared types and helpers for the udps_test_gates gate bank:
//            internal three-value code, Z->X collapse, gate function select.
// Revision : 1.0 - initial release
// ============================================================================
package udps_test_pkg;

  // Internal value code; Z never exists past the input decode.
  typedef enum logic [1:0] {
    L0 = 2'd0,
    L1 = 2'd1,
    LX = 2'd2
  } tv_e;

  typedef enum logic [1:0] {
    FN_AND = 2'd0,
    FN_OR  = 2'd1,
    FN_XOR = 2'd2
  } gate_fn_e;

  typedef struct packed {
    gate_fn_e fn;
    logic     inv;
  } gate_sel_t;

  localparam int GATE_CNT = 8;

  // Bit positions inside the registered result vector
  localparam int GI_NOT  = 0;
  localparam int GI_BUF  = 1;
  localparam int GI_AND  = 2;
  localparam int GI_OR   = 3;
  localparam int GI_XOR  = 4;
  localparam int GI_NAND = 5;
  localparam int GI_NOR  = 6;
  localparam int GI_XNOR = 7;

  // case matching is exact, so X and Z both fall to the default arm
  function automatic tv_e to_tv(input logic v);
    case (v)
      1'b0:    return L0;
      1'b1:    return L1;
      default: return LX;
    endcase
  endfunction

  // Logical inversion that keeps unknown unknown
  function automatic tv_e tv_inv(input tv_e v);
    case (v)
      L0:      return L1;
      L1:      return L0;
      default: return LX;
    endcase
  endfunction

  // Back to a pin value; an unknown result drives X, never Z
  function automatic logic from_tv(input tv_e v);
    case (v)
      L0:      return 1'b0;
      L1:      return 1'b1;
      default: return 1'bx;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/udps_test_gates_if.sv
`default_nettype none
// ============================================================================
// Module   : udps_test_gates_if
// Purpose  : Operand and result bundle of the udps_test_gates gate bank.
//            in_unknown exists only when UDPS_TEST_XFLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface udps_test_gates_if;
  logic src1;
  logic src2;
  logic src3;
  logic out_not;
  logic out_buf;
  logic out_and;
  logic out_or;
  logic out_xor;
  logic out_nand;
  logic out_nor;
  logic out_xnor;
`ifdef UDPS_TEST_XFLAG_EN
  logic in_unknown;
`endif

  modport master (
    output src1, src2, src3,
    input  out_not, out_buf, out_and, out_or, out_xor,
    input  out_nand, out_nor, out_xnor
`ifdef UDPS_TEST_XFLAG_EN
    , input in_unknown
`endif
  );

  modport slave (
    input  src1, src2, src3,
    output out_not, out_buf, out_and, out_or, out_xor,
    output out_nand, out_nor, out_xnor
`ifdef UDPS_TEST_XFLAG_EN
    , output in_unknown
`endif
  );
endinterface
`default_nettype wire

// File: rtl/udps_tv_eval.sv
`default_nettype none
// ============================================================================
// Module   : udps_tv_eval
// Purpose  : Combinational three-input AND/OR/XOR evaluator on the internal
//            three-value code, with optional output inversion.
// Revision : 1.0 - initial release
// ============================================================================
module udps_tv_eval
  import udps_test_pkg::*;
(
  input  tv_e       a,
  input  tv_e       b,
  input  tv_e       c,
  input  gate_sel_t sel,
  output tv_e       y
);

  tv_e raw;

  // Operands come from the exact-match decode, so they are always known
  // codes and plain equality on them is safe.
  always_comb begin
    raw = LX;
    case (sel.fn)
      FN_AND: begin
        if (a == L0 || b == L0 || c == L0)      raw = L0;
        else if (a == L1 && b == L1 && c == L1) raw = L1;
        else                                    raw = LX;
      end
      FN_OR: begin
        if (a == L1 || b == L1 || c == L1)      raw = L1;
        else if (a == L0 && b == L0 && c == L0) raw = L0;
        else                                    raw = LX;
      end
      FN_XOR: begin
        if (a == LX || b == LX || c == LX) raw = LX;
        else raw = tv_e'({1'b0, (a == L1) ^ (b == L1) ^ (c == L1)});
      end
      default: raw = LX;
    endcase
    y = sel.inv ? tv_inv(raw) : raw;
  end

endmodule
`default_nettype wire

// File: rtl/udps_test_gates.sv
`default_nettype none
// ============================================================================
// Module   : udps_test_gates
// Purpose  : Registered four-state gate bank (not, buf, and, or, xor, nand,
//            nor, xnor) on three 1-bit operands with primitive X semantics.
//            Optional macro UDPS_TEST_XFLAG_EN adds the in_unknown flag.
// Revision : 1.0 - initial release
// ============================================================================
module udps_test_gates
  import udps_test_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  udps_test_gates_if.slave  bus
);

  localparam gate_sel_t SEL_AND = '{fn: FN_AND, inv: 1'b0};
  localparam gate_sel_t SEL_OR  = '{fn: FN_OR,  inv: 1'b0};
  localparam gate_sel_t SEL_XOR = '{fn: FN_XOR, inv: 1'b0};

  tv_e a_tv, b_tv, c_tv;
  tv_e and_tv, or_tv, xor_tv;

  logic [GATE_CNT-1:0] gates_d;
  logic [GATE_CNT-1:0] gates_q;

  // Collapse Z onto X at the pins; nothing downstream sees Z
  always_comb begin
    a_tv = to_tv(bus.src1);
    b_tv = to_tv(bus.src2);
    c_tv = to_tv(bus.src3);
  end

  udps_tv_eval u_and (.a(a_tv), .b(b_tv), .c(c_tv), .sel(SEL_AND), .y(and_tv));
  udps_tv_eval u_or  (.a(a_tv), .b(b_tv), .c(c_tv), .sel(SEL_OR),  .y(or_tv));
  udps_tv_eval u_xor (.a(a_tv), .b(b_tv), .c(c_tv), .sel(SEL_XOR), .y(xor_tv));

  // Next-state result vector; inverted gates derive from their true form
  always_comb begin
    gates_d          = '0;
    gates_d[GI_NOT]  = from_tv(tv_inv(a_tv));
    gates_d[GI_BUF]  = from_tv(a_tv);
    gates_d[GI_AND]  = from_tv(and_tv);
    gates_d[GI_OR]   = from_tv(or_tv);
    gates_d[GI_XOR]  = from_tv(xor_tv);
    gates_d[GI_NAND] = from_tv(tv_inv(and_tv));
    gates_d[GI_NOR]  = from_tv(tv_inv(or_tv));
    gates_d[GI_XNOR] = from_tv(tv_inv(xor_tv));
  end

  // Output register; an unknown rst takes the else branch (not asserted)
  always_ff @(posedge clk) begin
    if (rst) gates_q <= '0;
    else     gates_q <= gates_d;
  end

  assign bus.out_not  = gates_q[GI_NOT];
  assign bus.out_buf  = gates_q[GI_BUF];
  assign bus.out_and  = gates_q[GI_AND];
  assign bus.out_or   = gates_q[GI_OR];
  assign bus.out_xor  = gates_q[GI_XOR];
  assign bus.out_nand = gates_q[GI_NAND];
  assign bus.out_nor  = gates_q[GI_NOR];
  assign bus.out_xnor = gates_q[GI_XNOR];

`ifdef UDPS_TEST_XFLAG_EN
  logic xflag_d;
  logic xflag_q;

  // Any operand outside {0,1} raises the flag
  always_comb begin
    xflag_d = (a_tv == LX) || (b_tv == LX) || (c_tv == LX);
  end

  // Flag register, aligned with the gate results
  always_ff @(posedge clk) begin
    if (rst) xflag_q <= 1'b0;
    else     xflag_q <= xflag_d;
  end

  assign bus.in_unknown = xflag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udps_test_gates.sv
`default_nettype none
// ============================================================================
// Module   : tb_udps_test_gates
// Purpose  : Self-checking bench for udps_test_gates: reset, directed X/Z
//            cases, shuffled exhaustive sweep with mid-stream reset, random.
//            Honours UDPS_TEST_XFLAG_EN for the in_unknown output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udps_test_gates;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  udps_test_gates_if bus ();

  udps_test_gates dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  string names [8] = '{"not", "buf", "and", "or", "xor", "nand", "nor", "xnor"};

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // 0 = zero, 1 = one, 2 = unknown (X or Z)
  function automatic int cls(input logic v);
    if (v === 1'b0) return 0;
    if (v === 1'b1) return 1;
    return 2;
  endfunction

  function automatic logic v4(input int k);
    case (k)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'bx;
      default: return 1'bz;
    endcase
  endfunction

  // Golden model from the counting rules; bit order matches names[]
  function automatic logic [7:0] model(input logic a, input logic b, input logic c);
    int n0, n1, nx, ca;
    logic g_not, g_and, g_or, g_xor;
    n0 = 0; n1 = 0; nx = 0;
    foreach (names[i]) begin end
    for (int i = 0; i < 3; i++) begin
      int k;
      k = cls(i == 0 ? a : (i == 1 ? b : c));
      if (k == 0) n0++;
      else if (k == 1) n1++;
      else nx++;
    end
    ca    = cls(a);
    g_not = (ca == 2) ? 1'bx : ((ca == 1) ? 1'b0 : 1'b1);
    g_and = (n0 > 0) ? 1'b0 : ((n1 == 3) ? 1'b1 : 1'bx);
    g_or  = (n1 > 0) ? 1'b1 : ((n0 == 3) ? 1'b0 : 1'bx);
    g_xor = (nx > 0) ? 1'bx : ((n1 % 2 == 1) ? 1'b1 : 1'b0);
    return {~g_xor, ~g_or, ~g_and, g_xor, g_or, g_and, ~g_not, g_not};
  endfunction

  function automatic logic [7:0] observed();
    return {bus.out_xnor, bus.out_nor, bus.out_nand, bus.out_xor,
            bus.out_or, bus.out_and, bus.out_buf, bus.out_not};
  endfunction

  task automatic check_vec(input string pfx, input logic [7:0] exp, input logic xf);
    logic [7:0] obs;
    obs = observed();
    for (int i = 0; i < 8; i++) check({pfx, "_", names[i]}, obs[i], exp[i]);
`ifdef UDPS_TEST_XFLAG_EN
    check({pfx, "_in_unknown"}, bus.in_unknown, xf);
`else
    if (xf === 1'b1) begin end
`endif
  endtask

  // One vector per cycle: drive at negedge, check 1 ns after the next posedge
  task automatic apply(input string pfx, input logic a, input logic b, input logic c);
    logic xf;
    @(negedge clk);
    bus.src1 = a; bus.src2 = b; bus.src3 = c;
    @(posedge clk);
    #1;
    xf = (cls(a) == 2) || (cls(b) == 2) || (cls(c) == 2);
    check_vec(pfx, model(a, b, c), xf);
  endtask

  task automatic reset_cycle(input string pfx);
    @(negedge clk);
    rst = 1'b1;
    bus.src1 = 1'($urandom_range(0, 1));
    bus.src2 = 1'b1;
    bus.src3 = 1'b1;
    @(posedge clk);
    #1;
    check_vec(pfx, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [64];
    int rix;
    logic a, b, c;

    rst = 1'b1;
    bus.src1 = 1'b1; bus.src2 = 1'b1; bus.src3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst", 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Binary case against literal expectations, then against the model
    apply("bin", 1'b1, 1'b0, 1'b1);
    begin
      logic [7:0] lit;
      lit = 8'b1010_1010;
      for (int i = 0; i < 8; i++) check({"lit_", names[i]}, observed() >> i, lit[i]);
    end

    a = v4(0); b = v4(2); c = v4(3);
    apply("dom", a, b, c);
    a = v4(3); b = v4(1); c = v4(1);
    apply("zc", a, b, c);

    // Shuffled exhaustive sweep with one reset dropped in mid-stream
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    rix = $urandom_range(10, 50);
    for (int k = 0; k < 64; k++) begin
      if (k == rix) reset_cycle("mid_rst");
      a = v4(order[k] % 4);
      b = v4((order[k] / 4) % 4);
      c = v4(order[k] / 16);
      apply("sweep", a, b, c);
    end

    // Random back-to-back traffic
    for (int k = 0; k < 100; k++) begin
      a = v4($urandom_range(0, 3));
      b = v4($urandom_range(0, 3));
      c = v4($urandom_range(0, 3));
      apply("rand", a, b, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
